// File: rtl/shift_deserializer_if.sv
// Bundles the serial-in side and the parallel-out handshake of shift_deserializer.
// Latency: none, wiring only.
// Backpressure: none; q_ack only clears q_valid, and the serial side is never stalled.
interface shift_deserializer_if #(
    parameter int WIDTH = 4
);
    // Serial side and consumer controls (driven toward the receiver)
    logic             clr;
    logic             sin_valid;
    logic             sin;
    logic             lr;
    logic             q_ack;

    // Parallel side and status (driven by the receiver)
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    // Producer/consumer view: drives the serial stream and the acknowledge
    modport master (
        output clr, sin_valid, sin, lr, q_ack,
        input  q, q_valid, busy, overrun, parity_err
    );

    // Receiver view
    modport slave (
        input  clr, sin_valid, sin, lr, q_ack,
        output q, q_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out word receiver; bit order (MSB- or LSB-first) is chosen per word from lr.
// Latency: q/q_valid update on the edge that samples the last bit (data bit WIDTH, or the parity bit).
// Backpressure: none; a word completing over an unacked q overwrites it and pulses overrun.
// Build option: define PARITY_CHECK_EN to expect one trailing even-parity bit per word.
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    shift_deserializer_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_PAR  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;
`endif

    // Word-assembly state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic             r_dir;
    logic             w_dir_nxt;

    // Shift datapath
    logic             w_shift_dir;
    logic [WIDTH-1:0] w_sr_shift;

    // Completion event for the output stage
    logic             w_done;
    logic [WIDTH-1:0] w_word;

    // Output stage
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_overrun;

`ifdef PARITY_CHECK_EN
    logic             w_par_bad;
    logic             r_parity_err;
`endif

    // Candidate shift-register value if this cycle's bit is taken; the first bit
    // of a word uses the live lr because dir is only being latched on that edge.
    always_comb begin
        w_shift_dir = r_dir;
        w_sr_shift  = r_sr;
        if (r_state == S_IDLE) begin
            w_shift_dir = bus.lr;
        end
        if (w_shift_dir) begin
            w_sr_shift = {r_sr[WIDTH-2:0], bus.sin};
        end else begin
            w_sr_shift = {bus.sin, r_sr[WIDTH-1:1]};
        end
    end

    // Next-state logic: bit collection, abort and word completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_dir_nxt   = r_dir;
        w_done      = 1'b0;
        w_word      = r_sr;
`ifdef PARITY_CHECK_EN
        w_par_bad   = 1'b0;
`endif
        if (bus.clr) begin
            // Abort wins over any bit on this edge, including the final one.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_sr_nxt    = '0;
        end else if (bus.sin_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    w_dir_nxt   = bus.lr;
                    w_sr_nxt    = w_sr_shift;
                    w_cnt_nxt   = ONE;
                    w_state_nxt = S_RECV;
                end
                S_RECV: begin
                    w_sr_nxt  = w_sr_shift;
                    w_cnt_nxt = r_cnt + ONE;
                    if (r_cnt == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
                        // Data complete; the parity bit still has to arrive.
                        w_state_nxt = S_PAR;
`else
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_done      = 1'b1;
                        w_word      = w_sr_shift;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PAR: begin
                    // Parity bit is not shifted in; the word is already whole in r_sr.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                    w_word      = r_sr;
                    w_par_bad   = ^{r_sr, bus.sin};
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register for the word-assembly FSM and its datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Output word and handshake: completion beats ack, ack alone clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                r_q       <= w_word;
                r_q_valid <= 1'b1;
                r_overrun <= r_q_valid & ~bus.q_ack;
            end else if (bus.q_ack) begin
                r_q_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    // One-cycle parity error flag, raised alongside the completing word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_done & w_par_bad;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.overrun = r_overrun;
    assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: a bit-list reference model checked every cycle,
// plus literal expectations for each scenario (order, gaps, overrun, abort, reset, parity).
// Inputs change on the falling edge; outputs and the model are compared on the falling edge.
`timescale 1ns/1ps
module tb_shift_deserializer;
    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;

    shift_deserializer_if #(.WIDTH(W)) bus ();

    shift_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bits of the word in progress are kept in arrival order; the word value is
    // rebuilt arithmetically from that list when it completes.
    bit           m_bits[$];
    bit           m_dir    = 1'b0;
    bit           m_inpar  = 1'b0;
    logic [W-1:0] m_held   = '0;
    logic [W-1:0] m_q      = '0;
    bit           m_qv     = 1'b0;
    bit           m_ovr    = 1'b0;
    bit           m_perr   = 1'b0;
    bit           m_done;
    logic [W-1:0] m_new;

    function automatic logic [W-1:0] build_word(input bit msb_first);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) v = v + (W'(m_bits[i]) << (W - 1 - i));
            else           v = v + (W'(m_bits[i]) << i);
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bits.delete();
            m_dir   = 1'b0;
            m_inpar = 1'b0;
            m_held  = '0;
            m_q     = '0;
            m_qv    = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
        end else begin
            m_done = 1'b0;
            m_new  = '0;
            m_perr = 1'b0;
            if (bus.clr) begin
                m_bits.delete();
                m_inpar = 1'b0;
            end else if (bus.sin_valid) begin
                if (m_inpar) begin
                    m_perr  = (($countones(m_held) + int'(bus.sin)) % 2) != 0;
                    m_new   = m_held;
                    m_done  = 1'b1;
                    m_inpar = 1'b0;
                end else begin
                    if (m_bits.size() == 0) m_dir = bus.lr;
                    m_bits.push_back(bus.sin);
                    if (m_bits.size() == W) begin
                        m_held = build_word(m_dir);
                        m_bits.delete();
                        if (HAS_PAR) begin
                            m_inpar = 1'b1;
                        end else begin
                            m_new  = m_held;
                            m_done = 1'b1;
                        end
                    end
                end
            end
            m_ovr = m_done && m_qv && !bus.q_ack;
            if (m_done) begin
                m_q  = m_new;
                m_qv = 1'b1;
            end else if (bus.q_ack) begin
                m_qv = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cyc_q",          32'(bus.q),          32'(m_q));
            check("cyc_q_valid",    32'(bus.q_valid),    32'(m_qv));
            check("cyc_busy",       32'(bus.busy),       32'((m_bits.size() != 0) || m_inpar));
            check("cyc_overrun",    32'(bus.overrun),    32'(m_ovr));
            check("cyc_parity_err", 32'(bus.parity_err), 32'(m_perr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic s, input logic l, input logic a, input logic c);
        @(negedge clk);
        bus.sin_valid = v;
        bus.sin       = s;
        bus.lr        = l;
        bus.q_ack     = a;
        bus.clr       = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // seq[W-1] goes on the wire first; q_ack rides on the word's final bit if requested.
    task automatic send_word(input logic l, input logic [W-1:0] seq, input logic ack_last);
        for (int i = W - 1; i >= 0; i--) begin
            drive(1'b1, seq[i], l, ack_last && (i == 0) && !HAS_PAR, 1'b0);
        end
        if (HAS_PAR) drive(1'b1, ^seq, l, ack_last, 1'b0);
    endtask

    initial begin
        bus.clr       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
        bus.lr        = 1'b0;
        bus.q_ack     = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_q",          32'(bus.q),          32'h0);
        check("rst_q_valid",    32'(bus.q_valid),    32'h0);
        check("rst_busy",       32'(bus.busy),       32'h0);
        check("rst_overrun",    32'(bus.overrun),    32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // MSB-first
        send_word(1'b1, 4'b1011, 1'b0);
        idle();
        check("msb_q",       32'(bus.q),       32'hB);
        check("msb_q_valid", 32'(bus.q_valid), 32'h1);
        check("msb_busy",    32'(bus.busy),    32'h0);
        ack();
        idle();
        check("ack_clears",  32'(bus.q_valid), 32'h0);

        // LSB-first
        send_word(1'b0, 4'b1011, 1'b0);
        idle();
        check("lsb_q", 32'(bus.q), 32'hD);
        ack();

        // Gapped bits 0,1,1,0 with valid pattern 1,0,0,1,1,0,1
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_busy1", 32'(bus.busy), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_busy2", 32'(bus.busy), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (HAS_PAR) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("gap_q",    32'(bus.q),    32'h6);
        check("gap_busy", 32'(bus.busy), 32'h0);
        ack();

        // Overrun: A unacked, then 5
        send_word(1'b1, 4'hA, 1'b0);
        idle();
        check("ovr_first_none", 32'(bus.overrun), 32'h0);
        send_word(1'b1, 4'h5, 1'b0);
        idle();
        check("ovr_q",       32'(bus.q),       32'h5);
        check("ovr_q_valid", 32'(bus.q_valid), 32'h1);
        check("ovr_pulse",   32'(bus.overrun), 32'h1);
        idle();
        check("ovr_one_cyc", 32'(bus.overrun), 32'h0);

        // Completion with q_ack on the same edge: no overrun, valid stays
        send_word(1'b1, 4'hA, 1'b1);
        idle();
        check("ackc_q",       32'(bus.q),       32'hA);
        check("ackc_q_valid", 32'(bus.q_valid), 32'h1);
        check("ackc_no_ovr",  32'(bus.overrun), 32'h0);
        ack();

        // Abort after two bits, then a full word of ones
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        check("clr_busy", 32'(bus.busy), 32'h0);
        send_word(1'b1, 4'hF, 1'b0);
        idle();
        check("clr_q", 32'(bus.q), 32'hF);
        ack();

        // Abort on the edge carrying the final data bit suppresses completion
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        check("clrlast_q",       32'(bus.q),       32'hF);
        check("clrlast_q_valid", 32'(bus.q_valid), 32'h0);
        check("clrlast_busy",    32'(bus.busy),    32'h0);

        // lr flips after the first bit are ignored: MSB-first 1,0,0,0
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (HAS_PAR) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("lrhold_q", 32'(bus.q), 32'h8);

        // Back-to-back words with no idle cycle, no ack: second overwrites, overrun
        send_word(1'b1, 4'h3, 1'b0);
        send_word(1'b0, 4'b0011, 1'b0);
        idle();
        check("b2b_q",   32'(bus.q),       32'hC);
        check("b2b_ovr", 32'(bus.overrun), 32'h1);

        // Reset mid-word (q_valid is 1 here): outputs clear before the next edge
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_q",       32'(bus.q),       32'h0);
        check("arst_q_valid", 32'(bus.q_valid), 32'h0);
        check("arst_busy",    32'(bus.busy),    32'h0);
        check("arst_overrun", 32'(bus.overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check("post_rst_q",    32'(bus.q),    32'h0);

`ifdef PARITY_CHECK_EN
        // Correct even parity
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_busy_in_par", 32'(bus.busy), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check("par_ok_q",   32'(bus.q),          32'hB);
        check("par_ok_err", 32'(bus.parity_err), 32'h0);
        ack();
        // Wrong parity bit
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        check("par_bad_q",       32'(bus.q),          32'hB);
        check("par_bad_q_valid", 32'(bus.q_valid),    32'h1);
        check("par_bad_err",     32'(bus.parity_err), 32'h1);
        idle();
        check("par_err_one_cyc", 32'(bus.parity_err), 32'h0);
`endif

        repeat (2) idle();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a runaway simulation.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
